// File: rtl/stream_slice_packer.sv
// Packs SLICE-bit input slices into WIDTH-bit words: collect buffer plus output register.
// Left-stream ordering (dir=1) exists only when STREAM_PACK_LSTREAM_EN is defined.
module stream_slice_packer #(
  parameter  int SLICE  = 2,
  parameter  int NSLICE = 2,
  localparam int WIDTH  = SLICE * NSLICE,
  localparam int CW     = $clog2(NSLICE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SLICE-1:0] in_data,
  input  logic             in_last,
  input  logic             dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_nslices
);

  typedef logic [NSLICE-1:0][SLICE-1:0] slices_t;

  slices_t          buf_q, buf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             closed_q, closed_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    out_nslices_q, out_nslices_d;
  logic             dir_eff;

`ifdef STREAM_PACK_LSTREAM_EN
  assign dir_eff = dir;
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign dir_eff    = 1'b0;
`endif

  // Slot p=0 is the MSB slice; unused slots stay zero.
  function automatic logic [WIDTH-1:0] pack(input slices_t s, input logic [CW-1:0] k,
                                            input logic d);
    logic [WIDTH-1:0] w;
    int               p;
    w = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (i < int'(k)) begin
        p = d ? (int'(k) - 1 - i) : i;
        w[WIDTH-1-p*SLICE -: SLICE] = s[i];
      end
    end
    return w;
  endfunction

  // A held word leaves when the output is consumed, so in_ready can follow out_ready.
  assign in_ready = !closed_q || out_ready;

  always_comb begin
    logic          accept;
    logic          out_free;
    logic [CW-1:0] k;
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    buf_d         = buf_q;
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    closed_d      = closed_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_nslices_d = out_nslices_q;
    out_free      = !out_valid_q || out_ready;
    accept        = in_valid && in_ready;
    k             = '0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (closed_q && out_ready) begin
      out_valid_d   = 1'b1;
      out_data_d    = pack(buf_q, cnt_q, dir_q);
      out_nslices_d = cnt_q;
      cnt_d         = '0;
      closed_d      = 1'b0;
      out_free      = 1'b0;
    end

    if (accept) begin
      if (cnt_d == '0) dir_d = dir_eff;
      for (int i = 0; i < NSLICE; i++) begin
        if (i == int'(cnt_d)) buf_d[i] = in_data;
      end
      k = cnt_d + 1'b1;
      if (in_last || k == CW'(NSLICE)) begin
        if (out_free) begin
          out_valid_d   = 1'b1;
          out_data_d    = pack(buf_d, k, dir_d);
          out_nslices_d = k;
          cnt_d         = '0;
        end else begin
          cnt_d    = k;
          closed_d = 1'b1;
        end
      end else begin
        cnt_d = k;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      dir_q         <= 1'b0;
      closed_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_nslices_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      closed_q      <= closed_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_nslices_q <= out_nslices_d;
    end
  end

  // NOTE: slice storage is not reset; cnt_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_nslices = out_nslices_q;

endmodule

// File: tb/tb_stream_slice_packer.sv
// Directed bench for stream_slice_packer at SLICE=2, NSLICE=2.
// Expected left-stream results depend on STREAM_PACK_LSTREAM_EN.
module tb_stream_slice_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_data;
  logic       in_last;
  logic       dir;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_nslices;

  int total = 0;
  int bad   = 0;

`ifdef STREAM_PACK_LSTREAM_EN
  localparam logic [3:0] LEFT_0111 = 4'b1101;
`else
  localparam logic [3:0] LEFT_0111 = 4'b0111;
`endif

  stream_slice_packer #(.SLICE(2), .NSLICE(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .dir         (dir),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_nslices (out_nslices)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One slice offered for exactly one cycle; junk driven on the idle bus afterwards.
  task automatic send(input string tag, input logic [1:0] d, input logic l, input logic dr);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    dir      = dr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;
    in_last  = 1'b1;
    dir      = ~dr;
  endtask

  task automatic expect_word(input string tag, input logic [3:0] d, input logic [1:0] n);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(d));
    check({tag, "_nslices"}, 32'(out_nslices), 32'(n));
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 2'b00;
    in_last   = 1'b0;
    dir       = 1'b0;
    out_ready = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_nslices", 32'(out_nslices), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    idle_cycle();
    idle_cycle();
    rst = 1'b0;
    idle_cycle();
    check("idle_no_word", 32'(out_valid), 32'd0);

    // Right-stream full word.
    send("r0", 2'b01, 1'b0, 1'b0);
    check("r0_not_yet", 32'(out_valid), 32'd0);
    send("r1", 2'b11, 1'b0, 1'b0);
    expect_word("right", 4'b0111, 2'd2);
    idle_cycle();
    check("right_consumed", 32'(out_valid), 32'd0);

    // Left-stream full word.
    send("l0", 2'b01, 1'b0, 1'b1);
    send("l1", 2'b11, 1'b0, 1'b1);
    expect_word("left", LEFT_0111, 2'd2);
    idle_cycle();

    // Early close with in_last, both directions.
    send("last_r", 2'b01, 1'b1, 1'b0);
    expect_word("last_r", 4'b0100, 2'd1);
    idle_cycle();
    send("last_l", 2'b01, 1'b1, 1'b1);
    expect_word("last_l", 4'b0100, 2'd1);
    idle_cycle();

    // dir sampled only with the first slice.
    send("t0", 2'b01, 1'b0, 1'b0);
    send("t1", 2'b11, 1'b0, 1'b1);
    expect_word("toggle_r", 4'b0111, 2'd2);
    send("u0", 2'b01, 1'b0, 1'b1);
    send("u1", 2'b11, 1'b0, 1'b0);
    expect_word("toggle_l", LEFT_0111, 2'd2);
    idle_cycle();

    // Back-to-back stream at full throughput.
    send("s0", 2'b10, 1'b0, 1'b0);
    send("s1", 2'b01, 1'b0, 1'b0);
    expect_word("stream_a", 4'b1001, 2'd2);
    send("s2", 2'b00, 1'b0, 1'b0);
    check("stream_gap", 32'(out_valid), 32'd0);
    send("s3", 2'b11, 1'b0, 1'b0);
    expect_word("stream_b", 4'b0011, 2'd2);
    idle_cycle();

    // Backpressure: second word held in collect buffer.
    out_ready = 1'b0;
    send("b0", 2'b01, 1'b0, 1'b0);
    send("b1", 2'b10, 1'b0, 1'b0);
    expect_word("bp_first", 4'b0110, 2'd2);
    send("b2", 2'b11, 1'b0, 1'b0);
    send("b3", 2'b00, 1'b0, 1'b0);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    idle_cycle();
    expect_word("bp_hold", 4'b0110, 2'd2);
    check("bp_still_blocked", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    idle_cycle();
    expect_word("bp_second", 4'b1100, 2'd2);
    idle_cycle();
    check("bp_drained", 32'(out_valid), 32'd0);
    idle_cycle();
    check("bp_no_dup", 32'(out_valid), 32'd0);

    // Asynchronous reset discards a partial word.
    send("p0", 2'b11, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    idle_cycle();
    rst = 1'b0;
    send("q0", 2'b10, 1'b0, 1'b0);
    check("post_rst_partial", 32'(out_valid), 32'd0);
    send("q1", 2'b00, 1'b0, 1'b0);
    expect_word("post_rst", 4'b1000, 2'd2);
    idle_cycle();
    check("post_rst_only", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_slice_packer.md
STREAM_SLICE_PACKER -- requirements
Module: stream_slice_packer

Interface
REQ-001 SHALL have parameter SLICE, default 2, bits per input slice (1..32).
REQ-002 SHALL have parameter NSLICE, default 2, slices per packed word (2..16).
REQ-003 SHALL derive WIDTH = SLICE*NSLICE; it is not overridable.
REQ-004 SHALL have port clk  input  1  sole clock; all state on posedge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  slice offered.
REQ-007 SHALL have port in_ready  output  1  slice accepted when in_valid && in_ready.
REQ-008 SHALL have port in_data  input  SLICE  slice payload.
REQ-009 SHALL have port in_last  input  1  slice closes the word early (flush).
REQ-010 SHALL have port dir  input  1  0 = right-stream (>>), 1 = left-stream (<<).
REQ-011 SHALL have port out_valid  output  1  packed word available.
REQ-012 SHALL have port out_ready  input  1  word consumed when out_valid && out_ready.
REQ-013 SHALL have port out_data  output  WIDTH  packed word.
REQ-014 SHALL have port out_nslices  output  clog2(NSLICE+1)  count of valid slices in out_data (1..NSLICE).

Function
REQ-015 SHALL hold two stages: collect buffer (up to NSLICE slices plus count) and output register.
REQ-016 SHALL sample dir with the first slice of each word; dir changes mid-word are ignored for that word.
REQ-017 SHALL close a word when the NSLICE-th slice is accepted or when a slice with in_last=1 is accepted, giving k slices (1..NSLICE).
REQ-018 SHALL number output slot p=0 as the MSB slice (out_data[WIDTH-1 -: SLICE]) increasing toward LSB.
REQ-019 SHALL, for dir=0, place the i-th received slice (i from 0) in slot p=i.
REQ-020 SHALL, for dir=1, place the i-th received slice in slot p=k-1-i; bit order inside a slice is never changed.
REQ-021 SHALL zero all slots p>=k (left-justified, zero-padded).
REQ-022 SHALL assert out_valid on the cycle after the closing slice is accepted (1-cycle latency) when the output register is free.
REQ-023 SHALL hold out_data, out_nslices, and out_valid stable while out_valid && !out_ready.
REQ-024 SHALL drive in_ready = !(collect buffer holds a closed word waiting for the output register); a closed word moves to the output register on the same cycle the held word is consumed.
REQ-025 SHALL accept a new slice in the same cycle a closed word transfers; no bubble at full throughput (one slice per cycle sustained with out_ready=1).
REQ-026 SHALL ignore in_data, in_last, and dir when in_valid=0.

Reset
REQ-027 SHALL on rst drive out_valid=0, out_data=0, out_nslices=0, collect count=0, in_ready=1, immediately and independent of clk.
REQ-028 SHALL discard any partial or held word when rst asserts mid-operation; the first slice after rst deassertion starts a new word.

Configuration
REQ-029 SHALL compile in left-stream ordering only when macro STREAM_PACK_LSTREAM_EN is defined; REQ-020 then applies as written.
REQ-030 SHALL, without STREAM_PACK_LSTREAM_EN, ignore dir and always use dir=0 ordering; port dir remains present.

Verification (SLICE=2, NSLICE=2, WIDTH=4, out_ready=1 unless stated)
REQ-031 SHALL check: dir=0, slices 2'b01 then 2'b11 -> next cycle out_data=4'b0111, out_nslices=2.
REQ-032 SHALL check: dir=1 (macro defined), slices 2'b01 then 2'b11 -> out_data=4'b1101; with macro undefined -> 4'b0111.
REQ-033 SHALL check: slice 2'b01 with in_last=1, dir=0 or 1 -> out_data=4'b0100, out_nslices=1.
REQ-034 SHALL check: out_ready=0, stream 4 slices -> first word held, second word closes, in_ready=0; raise out_ready -> both words emitted in order, no loss or duplication.
REQ-035 SHALL check: dir toggled between slice 0 and slice 1 -> ordering follows dir at slice 0.
REQ-036 SHALL check: rst asserted after one slice, then slices 2'b10, 2'b00 with dir=0 -> out_data=4'b1000 only; no word from the pre-reset slice.
